// File: rtl/halfband_ctrl_if.sv
// Sample, coefficient and filter-side signals between the upstream source,
// the half-band sequencer and the dynamic-tap filter.
interface halfband_ctrl_if #(
   parameter int IW = 16,
   parameter int TW = 12
);
   logic          i_valid;
   logic          o_ready;
   logic [IW-1:0] i_sample;
   logic          i_load_start;
   logic          i_coef_valid;
   logic          o_coef_ready;
   logic [TW-1:0] i_coef;
   logic          o_filt_reset;
   logic          o_tap_wr;
   logic [TW-1:0] o_tap;
   logic          o_ce;
   logic [IW-1:0] o_sample;
   logic          o_busy;
   logic          o_loaded;

   modport master (
      output i_valid, i_sample, i_load_start, i_coef_valid, i_coef,
      input  o_ready, o_coef_ready, o_filt_reset, o_tap_wr, o_tap,
             o_ce, o_sample, o_busy, o_loaded
   );

   modport slave (
      input  i_valid, i_sample, i_load_start, i_coef_valid, i_coef,
      output o_ready, o_coef_ready, o_filt_reset, o_tap_wr, o_tap,
             o_ce, o_sample, o_busy, o_loaded
   );
endinterface

// File: rtl/halfband_ctrl.sv
// Sequencer in front of the dynamic-tap half-band filter: spaces sample strobes
// and runs the flush / coefficient-reload sequence.
module halfband_ctrl #(
   parameter int IW        = 16,
   parameter int TW        = 12,
   parameter int LGNTAPS   = 7,
   parameter int NCOEFF    = 27,
   parameter int SPACING   = 107,
   parameter int FLUSH_LEN = 2
) (
   input  logic            i_clk,
   input  logic            i_reset,
   halfband_ctrl_if.slave  bus
);
   localparam int GW = LGNTAPS + 1;
   localparam int CW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
   localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

   typedef enum logic [1:0] {FLUSH, LOAD, RUN} state_t;

   state_t        state_reg, state_next;
   state_t        after_reg, after_next;
   logic [FW-1:0] flush_reg, flush_next;
   logic [GW-1:0] gap_reg, gap_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          pend_reg, pend_next;
   logic          filt_reset_reg, filt_reset_next;
   logic          tap_wr_reg, tap_wr_next;
   logic          ce_reg, ce_next;
   logic          loaded_reg, loaded_next;
   logic [TW-1:0] tap_reg, tap_next;
   logic [IW-1:0] sample_reg, sample_next;

   logic ready, coef_ready, sample_hs, coef_hs;

   // A load request in the same cycle blocks sample acceptance so the load wins.
   assign ready      = (state_reg == RUN) && (gap_reg == '0) && !pend_reg && !bus.i_load_start;
   assign coef_ready = (state_reg == LOAD);
   assign sample_hs  = ready && bus.i_valid;
   assign coef_hs    = coef_ready && bus.i_coef_valid;

   always_comb begin
      state_next  = state_reg;
      after_next  = after_reg;
      flush_next  = flush_reg;
      gap_next    = gap_reg;
      cnt_next    = cnt_reg;
      pend_next   = pend_reg;
      tap_wr_next = 1'b0;
      ce_next     = 1'b0;
      loaded_next = loaded_reg;
      tap_next    = tap_reg;
      sample_next = sample_reg;
      case (state_reg)
         FLUSH: begin
            gap_next = '0;
            if (flush_reg == '0) state_next = after_reg;
            else                 flush_next = flush_reg - FW'(1);
         end
         LOAD: begin
            if (coef_hs) begin
               tap_wr_next = 1'b1;
               tap_next    = bus.i_coef;
               if (cnt_reg == CW'(NCOEFF - 1)) begin
                  cnt_next    = '0;
                  loaded_next = 1'b1;
                  state_next  = RUN;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         RUN: begin
            if (gap_reg != '0) gap_next = gap_reg - GW'(1);
            if (sample_hs) begin
               ce_next     = 1'b1;
               sample_next = bus.i_sample;
               gap_next    = GW'(SPACING);
            end
            // Reload only once the filter has finished its current computation.
            if (pend_reg && (gap_reg == '0)) begin
               pend_next  = 1'b0;
               state_next = FLUSH;
               after_next = LOAD;
               flush_next = FW'(FLUSH_LEN - 1);
            end else if (bus.i_load_start) begin
               pend_next = 1'b1;
            end
         end
         default: state_next = FLUSH;
      endcase
      filt_reset_next = (state_next == FLUSH);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg      <= FLUSH;
         after_reg      <= RUN;
         flush_reg      <= FW'(FLUSH_LEN - 1);
         gap_reg        <= '0;
         cnt_reg        <= '0;
         pend_reg       <= 1'b0;
         filt_reset_reg <= 1'b1;
         tap_wr_reg     <= 1'b0;
         ce_reg         <= 1'b0;
         loaded_reg     <= 1'b0;
         tap_reg        <= '0;
         sample_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         after_reg      <= after_next;
         flush_reg      <= flush_next;
         gap_reg        <= gap_next;
         cnt_reg        <= cnt_next;
         pend_reg       <= pend_next;
         filt_reset_reg <= filt_reset_next;
         tap_wr_reg     <= tap_wr_next;
         ce_reg         <= ce_next;
         loaded_reg     <= loaded_next;
         tap_reg        <= tap_next;
         sample_reg     <= sample_next;
      end
   end

   assign bus.o_ready      = ready;
   assign bus.o_coef_ready = coef_ready;
   assign bus.o_filt_reset = filt_reset_reg;
   assign bus.o_tap_wr     = tap_wr_reg;
   assign bus.o_tap        = tap_reg;
   assign bus.o_ce         = ce_reg;
   assign bus.o_sample     = sample_reg;
   assign bus.o_busy       = (state_reg != RUN);
   assign bus.o_loaded     = loaded_reg;
endmodule

// File: tb/tb_halfband_ctrl.sv
// Bench for halfband_ctrl: constant vector table, directed load/spacing/reset
// sequences and a random run, all against a timestamp-based reference model.
module tb_halfband_ctrl;
   localparam int IW        = 16;
   localparam int TW        = 12;
   localparam int LGNTAPS   = 7;
   localparam int NCOEFF    = 27;
   localparam int SPACING   = 107;
   localparam int FLUSH_LEN = 2;

   typedef struct packed {
      logic          ready;
      logic          coef_ready;
      logic          filt_reset;
      logic          tap_wr;
      logic          ce;
      logic          busy;
      logic          loaded;
      logic [TW-1:0] tap;
      logic [IW-1:0] sample;
   } outs_t;

   typedef struct {
      logic          v;
      logic [IW-1:0] s;
      logic          ls;
      outs_t         exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   halfband_ctrl_if #(.IW(IW), .TW(TW)) bus ();

   halfband_ctrl #(
      .IW(IW), .TW(TW), .LGNTAPS(LGNTAPS), .NCOEFF(NCOEFF),
      .SPACING(SPACING), .FLUSH_LEN(FLUSH_LEN)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: behaviour expressed as timestamps of events.
   int            t = 0;
   int            flush_end_t, last_acc_t, last_coef_t, ncoef;
   bit            pend, flush_to_load, in_load, loaded_m;
   logic [IW-1:0] exp_sample;
   logic [TW-1:0] exp_tap;

   outs_t obs;
   int    obs_t;
   int    tw_count, tw_bad;
   logic [TW-1:0] tw_next;

   function automatic outs_t mk(bit r, bit cr, bit fr, bit tw, bit ce, bit busy, bit ld,
                                logic [TW-1:0] tap, logic [IW-1:0] s);
      outs_t o;
      o.ready = r; o.coef_ready = cr; o.filt_reset = fr; o.tap_wr = tw; o.ce = ce;
      o.busy = busy; o.loaded = ld; o.tap = tap; o.sample = s;
      return o;
   endfunction

   function automatic outs_t sample_dut();
      return mk(bus.o_ready, bus.o_coef_ready, bus.o_filt_reset, bus.o_tap_wr, bus.o_ce,
                bus.o_busy, bus.o_loaded, bus.o_tap, bus.o_sample);
   endfunction

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic model_reset();
      flush_end_t = t + FLUSH_LEN;
      last_acc_t = -1000; last_coef_t = -1000; ncoef = 0;
      pend = 0; flush_to_load = 0; in_load = 0; loaded_m = 0;
      exp_sample = '0; exp_tap = '0;
   endtask

   task automatic do_reset();
      outs_t rv;
      rv = mk(0, 0, 1, 0, 0, 1, 0, '0, '0);
      @(negedge clk);
      rst = 1'b1;
      bus.i_valid = 0; bus.i_sample = '0; bus.i_load_start = 0;
      bus.i_coef_valid = 0; bus.i_coef = '0;
      #1;
      checks++;
      if (sample_dut() !== rv) begin
         errors++;
         $display("FAIL reset_async: got %h, expected %h", sample_dut(), rv);
      end
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (sample_dut() !== rv) begin
         errors++;
         $display("FAIL reset_hold: got %h, expected %h", sample_dut(), rv);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cycle(input logic v, input logic [IW-1:0] s, input logic ls,
                        input logic cv, input logic [TW-1:0] c);
      outs_t e;
      bit    in_flush, run, gap_ok;
      @(negedge clk);
      bus.i_valid = v; bus.i_sample = s; bus.i_load_start = ls;
      bus.i_coef_valid = cv; bus.i_coef = c;
      #1;
      if (flush_to_load && t == flush_end_t) begin
         in_load = 1; flush_to_load = 0;
      end
      in_flush = (t < flush_end_t);
      run      = !in_flush && !in_load;
      gap_ok   = (t >= last_acc_t + SPACING + 1);
      e = mk(run && gap_ok && !pend && !ls, in_load, in_flush, last_coef_t == t - 1,
             last_acc_t == t - 1, !run, loaded_m, exp_tap, exp_sample);
      obs   = sample_dut();
      obs_t = t;
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL outputs @%0d: got %h, expected %h", t, obs, e);
      end
      if (obs.ce) $display("t=%0d ce sample=%h", t, obs.sample);
      if (obs.tap_wr) begin
         $display("t=%0d tap_wr tap=%h", t, obs.tap);
         tw_count++;
         if (obs.tap !== tw_next) tw_bad++;
         tw_next = tw_next + 1'b1;
      end
      if (run) begin
         if (e.ready && v) begin
            last_acc_t = t; exp_sample = s;
         end
         if (pend && gap_ok) begin
            pend = 0; flush_end_t = t + 1 + FLUSH_LEN; flush_to_load = 1;
         end else if (ls) begin
            pend = 1;
         end
      end
      if (in_load && cv) begin
         last_coef_t = t; exp_tap = c; ncoef++;
         if (ncoef == NCOEFF) begin
            loaded_m = 1; ncoef = 0; in_load = 0;
         end
      end
      t++;
   endtask

   // Idles (optionally with valid held) until the controller asks for coefficients.
   task automatic wait_load(input logic v, input logic [IW-1:0] s,
                            output int filt_t, output int filt_n, output int nready);
      filt_t = -1; filt_n = 0; nready = 0;
      for (int i = 0; i < 400; i++) begin
         cycle(v, s, 0, 0, '0);
         if (obs.filt_reset) begin
            if (filt_t < 0) filt_t = obs_t;
            filt_n++;
         end
         if (obs.ready) nready++;
         if (obs.coef_ready) return;
      end
      chk("wait_load_timeout", 1, 0);
   endtask

   task automatic feed(input int n, input logic [TW-1:0] base, input bit toggle);
      int idx = 0;
      for (int i = 0; i < 400 && idx < n; i++) begin
         logic cv;
         cv = toggle ? (i % 3 == 0) : 1'b1;
         cycle(0, '0, 0, cv, base + TW'(idx));
         if (cv && obs.coef_ready) idx++;
      end
      chk("feed_done", idx, n);
   endtask

   initial begin
      vec_t tbl[7];
      int   t0, filt_t, filt_n, nready, nce, last_ce, bad, low, acc_t;
      logic [IW-1:0] smp;

      tbl[0] = '{1, 16'hAAAA, 0, mk(0, 0, 1, 0, 0, 1, 0, '0, '0)};
      tbl[1] = '{1, 16'hAAAA, 0, mk(0, 0, 1, 0, 0, 1, 0, '0, '0)};
      tbl[2] = '{1, 16'hAAAA, 0, mk(1, 0, 0, 0, 0, 0, 0, '0, '0)};
      tbl[3] = '{0, 16'h0000, 0, mk(0, 0, 0, 0, 1, 0, 0, '0, 16'hAAAA)};
      tbl[4] = '{1, 16'h5555, 0, mk(0, 0, 0, 0, 0, 0, 0, '0, 16'hAAAA)};
      tbl[5] = '{0, 16'h0000, 1, mk(0, 0, 0, 0, 0, 0, 0, '0, 16'hAAAA)};
      tbl[6] = '{1, 16'h1234, 0, mk(0, 0, 0, 0, 0, 0, 0, '0, 16'hAAAA)};
      tw_count = 0; tw_bad = 0; tw_next = '0;

      do_reset();
      t0 = t;
      for (int i = 0; i < 7; i++) begin
         cycle(tbl[i].v, tbl[i].s, tbl[i].ls, 0, '0);
         checks++;
         if (obs !== tbl[i].exp) begin
            errors++;
            $display("FAIL table[%0d]: got %h, expected %h", i, obs, tbl[i].exp);
         end
      end

      // Load requested while the filter is busy: flush waits for the gap to drain.
      wait_load(0, '0, filt_t, filt_n, nready);
      chk("load1_flush_start", filt_t, t0 + 2 + SPACING + 2);
      chk("load1_flush_len", filt_n, FLUSH_LEN);
      chk("load1_ready_low", nready, 0);
      tw_count = 0; tw_bad = 0; tw_next = 12'h001;
      feed(NCOEFF, 12'h001, 0);
      cycle(0, '0, 0, 0, '0);
      chk("load1_tap_wr_count", tw_count, NCOEFF);
      chk("load1_tap_order_bad", tw_bad, 0);
      chk("load1_loaded", obs.loaded, 1);

      // Valid held high: strobes every SPACING+1 cycles.
      smp = 16'h1000; nce = 0; last_ce = -1; bad = 0; low = 0;
      for (int i = 0; i < 340; i++) begin
         cycle(1, smp, 0, 0, '0);
         if (obs.ready) smp++;
         else low++;
         if (obs.ce) begin
            if (last_ce >= 0 && obs_t - last_ce != SPACING + 1) bad++;
            if (obs.sample !== smp - 1'b1) bad++;
            last_ce = obs_t;
            nce++;
         end
      end
      chk("stream_ce_count", nce, 4);
      chk("stream_spacing_bad", bad, 0);
      chk("stream_ready_low", low, 3 * SPACING + 15);

      // Load request 10 cycles after an accept, valid still held.
      acc_t = -1;
      for (int i = 0; i < 200 && acc_t < 0; i++) begin
         cycle(1, smp, 0, 0, '0);
         if (obs.ready) begin acc_t = obs_t; smp++; end
      end
      chk("accept_seen", acc_t >= 0, 1);
      repeat (9) cycle(1, smp, 0, 0, '0);
      cycle(1, smp, 1, 0, '0);
      wait_load(1, smp, filt_t, filt_n, nready);
      chk("load2_flush_start", filt_t, acc_t + SPACING + 2);
      chk("load2_ready_low", nready, 0);
      tw_count = 0; tw_bad = 0; tw_next = 12'h100;
      feed(NCOEFF, 12'h100, 1);
      // First RUN cycle: load and valid together, the load must win.
      cycle(1, 16'h7777, 1, 0, '0);
      chk("load2_tap_wr_count", tw_count, NCOEFF);
      chk("load2_tap_order_bad", tw_bad, 0);
      chk("load2_loaded", obs.loaded, 1);
      chk("load_wins_ready", obs.ready, 0);
      cycle(1, 16'h7777, 0, 0, '0);
      chk("load_wins_no_ce", obs.ce, 0);
      wait_load(0, '0, filt_t, filt_n, nready);
      chk("load3_flush_len", filt_n, FLUSH_LEN);

      // Reset after 10 coefficients discards the partial load.
      feed(10, 12'h200, 0);
      do_reset();
      repeat (3) cycle(0, '0, 0, 0, '0);
      cycle(0, '0, 1, 0, '0);
      wait_load(0, '0, filt_t, filt_n, nready);
      feed(NCOEFF - 1, 12'h300, 0);
      cycle(0, '0, 0, 0, '0);
      chk("partial_not_loaded", obs.loaded, 0);
      feed(1, 12'h3FF, 0);
      cycle(0, '0, 0, 0, '0);
      chk("reload_loaded", obs.loaded, 1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 4) != 0, IW'($urandom), ($urandom % 150) == 0,
               $urandom % 2, TW'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
